// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8-subset control unit driving every dataPath_core control input.
// The only flop is the state register; all controls decode combinationally from state and IR.
module control_sequencer #(
    parameter logic [1:0] DATA_SIZE = 2'b11,
    parameter logic [4:0] ZERO_REG  = 5'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic [3:0]  status,
    output logic        add_tri_sel,
    output logic [1:0]  data_tri_sel,
    output logic        w_reg,
    output logic        C0,
    output logic        mem_cs,
    output logic        mem_write_en,
    output logic        IR_load,
    output logic        status_load,
    output logic [31:0] k,
    output logic [4:0]  FS,
    output logic [1:0]  PC_FS,
    output logic [1:0]  size,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        PC_sel,
    output logic        B_Sel,
    output logic        halted,
    output logic [2:0]  state
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_BRANCH = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] CLS_ILL  = 4'd0;
    localparam logic [3:0] CLS_R    = 4'd1;
    localparam logic [3:0] CLS_I    = 4'd2;
    localparam logic [3:0] CLS_LD   = 4'd3;
    localparam logic [3:0] CLS_ST   = 4'd4;
    localparam logic [3:0] CLS_B    = 4'd5;
    localparam logic [3:0] CLS_BC   = 4'd6;
    localparam logic [3:0] CLS_CBZ  = 4'd7;
    localparam logic [3:0] CLS_CBNZ = 4'd8;
    localparam logic [3:0] CLS_BR   = 4'd9;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_ORR = 5'b01100;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cls_s;
    logic [4:0]  alu_fs_s;
    logic        alu_sub_s;
    logic        bc_taken_s, cb_taken_s;
    logic [31:0] k_imm_s, k_mem_s, k_b_s, k_cb_s;

    // Flags are {V,C,N,Z}; AL (E/F) and any unlisted code are treated as always.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic v, c, n, z, r;
        v = flags[3];
        c = flags[2];
        n = flags[1];
        z = flags[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~(c & ~z);
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Branch constants are offset-1 because PC already points past the branch.
    assign k_imm_s = {20'd0, IR[21:10]};
    assign k_mem_s = {{23{IR[20]}}, IR[20:12]};
    assign k_b_s   = {{6{IR[25]}}, IR[25:0]} - 32'd1;
    assign k_cb_s  = {{13{IR[23]}}, IR[23:5]} - 32'd1;

    assign bc_taken_s = cond_holds(IR[3:0], status);
    assign cb_taken_s = (cls_s == CLS_CBZ) ? status[0] : ~status[0];

    // Instruction classification from the opcode field
    always_comb begin
        cls_s     = CLS_ILL;
        alu_fs_s  = FS_AND;
        alu_sub_s = 1'b0;
        if (IR[31:21] == 11'b10001011000) begin
            cls_s    = CLS_R;
            alu_fs_s = FS_ADD;
        end else if (IR[31:21] == 11'b11001011000) begin
            cls_s     = CLS_R;
            alu_fs_s  = FS_SUB;
            alu_sub_s = 1'b1;
        end else if (IR[31:21] == 11'b10001010000) begin
            cls_s    = CLS_R;
            alu_fs_s = FS_AND;
        end else if (IR[31:21] == 11'b10101010000) begin
            cls_s    = CLS_R;
            alu_fs_s = FS_ORR;
        end else if (IR[31:22] == 10'b1001000100) begin
            cls_s    = CLS_I;
            alu_fs_s = FS_ADD;
        end else if (IR[31:22] == 10'b1101000100) begin
            cls_s     = CLS_I;
            alu_fs_s  = FS_SUB;
            alu_sub_s = 1'b1;
        end else if (IR[31:22] == 10'b1001001000) begin
            cls_s    = CLS_I;
            alu_fs_s = FS_AND;
        end else if (IR[31:22] == 10'b1011001000) begin
            cls_s    = CLS_I;
            alu_fs_s = FS_ORR;
        end else if (IR[31:21] == 11'b11111000010) begin
            cls_s = CLS_LD;
        end else if (IR[31:21] == 11'b11111000000) begin
            cls_s = CLS_ST;
        end else if (IR[31:21] == 11'b11010110000) begin
            cls_s = CLS_BR;
        end else if (IR[31:26] == 6'b000101) begin
            cls_s = CLS_B;
        end else if (IR[31:24] == 8'b01010100) begin
            cls_s = CLS_BC;
        end else if (IR[31:24] == 8'b10110100) begin
            cls_s = CLS_CBZ;
        end else if (IR[31:24] == 8'b10110101) begin
            cls_s = CLS_CBNZ;
        end else begin
            cls_s = CLS_ILL;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_HALT;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (cls_s == CLS_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (cls_s)
                    CLS_LD, CLS_ST:    state_d = S_MEM;
                    CLS_CBZ, CLS_CBNZ: state_d = S_BRANCH;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath control decode
    always_comb begin
        add_tri_sel  = 1'b0;
        data_tri_sel = 2'b00;
        w_reg        = 1'b0;
        C0           = 1'b0;
        mem_cs       = 1'b0;
        mem_write_en = 1'b0;
        IR_load      = 1'b0;
        status_load  = 1'b0;
        k            = 32'd0;
        FS           = FS_AND;
        PC_FS        = 2'b00;
        SA           = 5'd0;
        SB           = 5'd0;
        DA           = 5'd0;
        PC_sel       = 1'b0;
        B_Sel        = 1'b0;
        halted       = 1'b0;
        case (state_q)
            S_FETCH: begin
                add_tri_sel  = 1'b1;
                mem_cs       = 1'b1;
                data_tri_sel = 2'b11;
                IR_load      = 1'b1;
                PC_FS        = 2'b01;
            end
            S_DECODE: begin
            end
            S_EXEC: begin
                case (cls_s)
                    CLS_R, CLS_I: begin
                        SA    = IR[9:5];
                        SB    = IR[20:16];
                        DA    = IR[4:0];
                        FS    = alu_fs_s;
                        C0    = alu_sub_s;
                        w_reg = 1'b1;
                        B_Sel = (cls_s == CLS_I);
                        k     = (cls_s == CLS_I) ? k_imm_s : 32'd0;
                    end
                    CLS_LD, CLS_ST: begin
                        SA     = IR[9:5];
                        k      = k_mem_s;
                        B_Sel  = 1'b1;
                        FS     = FS_ADD;
                        mem_cs = 1'b1;
                        if (cls_s == CLS_ST) begin
                            SB           = IR[4:0];
                            data_tri_sel = 2'b01;
                        end else begin
                            SB = 5'd0;
                        end
                    end
                    CLS_B: begin
                        PC_FS = 2'b10;
                        k     = k_b_s;
                    end
                    CLS_BC: begin
                        if (bc_taken_s) begin
                            PC_FS = 2'b10;
                            k     = k_cb_s;
                        end else begin
                            PC_FS = 2'b00;
                        end
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        SA          = ZERO_REG;
                        SB          = IR[4:0];
                        FS          = FS_ADD;
                        status_load = 1'b1;
                    end
                    CLS_BR: begin
                        SB           = IR[9:5];
                        data_tri_sel = 2'b01;
                        PC_sel       = 1'b1;
                        PC_FS        = 2'b11;
                    end
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                SA     = IR[9:5];
                k      = k_mem_s;
                B_Sel  = 1'b1;
                FS     = FS_ADD;
                mem_cs = 1'b1;
                if (cls_s == CLS_ST) begin
                    SB           = IR[4:0];
                    data_tri_sel = 2'b01;
                    mem_write_en = 1'b1;
                end else begin
                    data_tri_sel = 2'b11;
                    DA           = IR[4:0];
                    w_reg        = 1'b1;
                end
            end
            S_BRANCH: begin
                if (cb_taken_s) begin
                    PC_FS = 2'b10;
                    k     = k_cb_s;
                end else begin
                    PC_FS = 2'b00;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign size  = DATA_SIZE;
    assign state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus random instructions checked
// against a per-instruction behavioural model built from instruction fields.
module tb_control_sequencer;
    logic        clock, reset;
    logic [31:0] IR;
    logic [3:0]  status;
    logic        add_tri_sel, w_reg, C0, mem_cs, mem_write_en, IR_load, status_load;
    logic [1:0]  data_tri_sel, PC_FS, size;
    logic [31:0] k;
    logic [4:0]  FS, SA, SB, DA;
    logic        PC_sel, B_Sel, halted;
    logic [2:0]  state;

    int checks = 0;
    int fails  = 0;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_B = 4, K_BC = 5;
    localparam int K_CBZ = 6, K_CBNZ = 7, K_BR = 8;

    typedef struct packed {
        logic        add;
        logic [1:0]  dts;
        logic        wr;
        logic        c0;
        logic        cs;
        logic        mwe;
        logic        irl;
        logic        stl;
        logic [31:0] k;
        logic [4:0]  fs;
        logic [1:0]  pcfs;
        logic [1:0]  sz;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        psel;
        logic        bsel;
        logic        hlt;
        logic [2:0]  st;
    } outs_t;

    typedef struct {
        int kind;
        int op;
        int rd;
        int rn;
        int rm;
        int imm;
        int off;
        int cond;
    } instr_t;

    control_sequencer dut (
        .clock(clock), .reset(reset), .IR(IR), .status(status),
        .add_tri_sel(add_tri_sel), .data_tri_sel(data_tri_sel), .w_reg(w_reg), .C0(C0),
        .mem_cs(mem_cs), .mem_write_en(mem_write_en), .IR_load(IR_load),
        .status_load(status_load), .k(k), .FS(FS), .PC_FS(PC_FS), .size(size),
        .SA(SA), .SB(SB), .DA(DA), .PC_sel(PC_sel), .B_Sel(B_Sel), .halted(halted),
        .state(state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic outs_t sample();
        return {add_tri_sel, data_tri_sel, w_reg, C0, mem_cs, mem_write_en, IR_load,
                status_load, k, FS, PC_FS, size, SA, SB, DA, PC_sel, B_Sel, halted, state};
    endfunction

    // ARM rule: code pairs share a base test, odd code inverts it, 15 is always.
    function automatic bit cond_ok(input int cond, input logic [3:0] f);
        bit z, n, c, v, base;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        case (cond / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 15) return 1'b1;
        return (cond % 2 == 1) ? !base : base;
    endfunction

    function automatic int n_phases(input int kind);
        return (kind == K_LD || kind == K_ST || kind == K_CBZ || kind == K_CBNZ) ? 4 : 3;
    endfunction

    function automatic logic [31:0] encode(input instr_t in);
        logic [10:0] o11;
        logic [9:0]  o10;
        case (in.op)
            0: begin o11 = 11'b10001011000; o10 = 10'b1001000100; end
            1: begin o11 = 11'b11001011000; o10 = 10'b1101000100; end
            2: begin o11 = 11'b10001010000; o10 = 10'b1001001000; end
            default: begin o11 = 11'b10101010000; o10 = 10'b1011001000; end
        endcase
        case (in.kind)
            K_R:    return {o11, 5'(in.rm), 6'(in.imm), 5'(in.rn), 5'(in.rd)};
            K_I:    return {o10, 12'(in.imm), 5'(in.rn), 5'(in.rd)};
            K_LD:   return {11'b11111000010, 9'(in.off), 2'b00, 5'(in.rn), 5'(in.rd)};
            K_ST:   return {11'b11111000000, 9'(in.off), 2'b00, 5'(in.rn), 5'(in.rd)};
            K_B:    return {6'b000101, 26'(in.off)};
            K_BC:   return {8'b01010100, 19'(in.off), 1'b0, 4'(in.cond)};
            K_CBZ:  return {8'b10110100, 19'(in.off), 5'(in.rd)};
            K_CBNZ: return {8'b10110101, 19'(in.off), 5'(in.rd)};
            K_BR:   return {11'b11010110000, 5'b11111, 6'b000000, 5'(in.rn), 5'b00000};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Expected controls for one cycle of an instruction; phase 0 is the fetch cycle.
    function automatic outs_t ref_out(input instr_t in, input int phase, input logic [3:0] f);
        outs_t o;
        bit taken;
        o = '0;
        o.sz = 2'b11;
        if (phase == 0) begin
            o.add = 1'b1; o.cs = 1'b1; o.dts = 2'b11; o.irl = 1'b1; o.pcfs = 2'b01;
            o.st = 3'd0;
        end else if (phase == 1) begin
            o.st = 3'd1;
        end else if (phase == 2) begin
            o.st = 3'd2;
            case (in.kind)
                K_R, K_I: begin
                    o.sa = 5'(in.rn); o.da = 5'(in.rd); o.wr = 1'b1;
                    if (in.kind == K_R) begin
                        o.sb = 5'(in.rm);
                    end else begin
                        o.sb = 5'(in.imm >> 6); o.bsel = 1'b1; o.k = 32'(in.imm);
                    end
                    case (in.op)
                        0: o.fs = 5'b01000;
                        1: begin o.fs = 5'b01001; o.c0 = 1'b1; end
                        2: o.fs = 5'b00000;
                        default: o.fs = 5'b01100;
                    endcase
                end
                K_LD, K_ST: begin
                    o.sa = 5'(in.rn); o.k = 32'(in.off); o.bsel = 1'b1; o.fs = 5'b01000;
                    o.cs = 1'b1;
                    if (in.kind == K_ST) begin
                        o.sb = 5'(in.rd); o.dts = 2'b01;
                    end
                end
                K_B: begin
                    o.pcfs = 2'b10; o.k = 32'(in.off - 1);
                end
                K_BC: begin
                    if (cond_ok(in.cond, f)) begin
                        o.pcfs = 2'b10; o.k = 32'(in.off - 1);
                    end
                end
                K_CBZ, K_CBNZ: begin
                    o.sa = 5'd31; o.sb = 5'(in.rd); o.fs = 5'b01000; o.stl = 1'b1;
                end
                K_BR: begin
                    o.sb = 5'(in.rn); o.dts = 2'b01; o.psel = 1'b1; o.pcfs = 2'b11;
                end
                default: o.st = 3'd2;
            endcase
        end else if (in.kind == K_LD || in.kind == K_ST) begin
            o.st = 3'd3;
            o.sa = 5'(in.rn); o.k = 32'(in.off); o.bsel = 1'b1; o.fs = 5'b01000; o.cs = 1'b1;
            if (in.kind == K_LD) begin
                o.dts = 2'b11; o.da = 5'(in.rd); o.wr = 1'b1;
            end else begin
                o.sb = 5'(in.rd); o.dts = 2'b01; o.mwe = 1'b1;
            end
        end else begin
            o.st = 3'd4;
            taken = (in.kind == K_CBZ) ? f[0] : !f[0];
            if (taken) begin
                o.pcfs = 2'b10; o.k = 32'(in.off - 1);
            end
        end
        return o;
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        in.kind = int'($urandom_range(0, 8));
        in.op   = int'($urandom_range(0, 3));
        in.rd   = int'($urandom_range(0, 31));
        in.rn   = int'($urandom_range(0, 31));
        in.rm   = int'($urandom_range(0, 31));
        in.imm  = int'($urandom_range(0, 4095));
        in.cond = int'($urandom_range(0, 15));
        if (in.kind == K_LD || in.kind == K_ST) in.off = int'($urandom_range(0, 511)) - 256;
        else if (in.kind == K_B) in.off = int'($urandom_range(0, 67108863)) - 33554432;
        else in.off = int'($urandom_range(0, 524287)) - 262144;
        if ($urandom_range(0, 7) == 0) in.off = 0;
        return in;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        instr_t d;
        outs_t  exp, act;
        d = '{kind: K_R, op: 0, rd: 0, rn: 0, rm: 0, imm: 0, off: 0, cond: 0};
        reset = 1'b1; IR = 32'h0; status = 4'h0;
        #2;
        exp = ref_out(d, 0, 4'h0);
        act = sample();
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", act, exp);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        instr_t ins [2];
        logic [31:0] irs [2];
        outs_t exp, act;
        ins[0] = '{kind: K_I, op: 0, rd: 1, rn: 0, rm: 0, imm: 5, off: 0, cond: 0};
        irs[0] = 32'h9100_1401;
        ins[1] = '{kind: K_R, op: 1, rd: 5, rn: 0, rm: 2, imm: 0, off: 0, cond: 0};
        irs[1] = 32'hCB02_0005;
        for (int i = 0; i < 2; i++) begin
            IR = irs[i];
            status = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                @(negedge clock);
                exp = ref_out(ins[i], p, status);
                act = sample();
                checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL alu[%0d] phase %0d: got %h required %h", i, p, act, exp);
                end
                next_cycle();
            end
        end
        @(negedge clock);
        checks++;
        if (state !== 3'd0 || IR_load !== 1'b1) begin
            fails++;
            $display("FAIL alu_return_fetch: got state %0d IR_load %b required 0/1", state, IR_load);
        end
        next_cycle();
        @(negedge clock);
        next_cycle();
        @(negedge clock);
        next_cycle();
    endtask

    task automatic test_stur_reset();
        instr_t ins;
        outs_t  exp, act;
        ins = '{kind: K_ST, op: 0, rd: 1, rn: 0, rm: 0, imm: 0, off: -8, cond: 0};
        IR = 32'hF81F_8001;
        status = 4'($urandom_range(0, 15));
        for (int p = 0; p < 4; p++) begin
            @(negedge clock);
            exp = ref_out(ins, p, status);
            act = sample();
            checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL stur phase %0d: got %h required %h", p, act, exp);
            end
            if (p < 3) next_cycle();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write_en !== 1'b0 || state !== 3'd0) begin
            fails++;
            $display("FAIL stur_reset_abort: got mwe %b state %0d required 0/0", mem_write_en, state);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_cbz();
        instr_t ins;
        outs_t  exp, act;
        logic   z;
        ins = '{kind: K_CBZ, op: 0, rd: 3, rn: 0, rm: 0, imm: 0, off: 4, cond: 0};
        for (int i = 0; i < 2; i++) begin
            z = (i == 0);
            IR = 32'hB400_0083;
            status = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                if (p == 3) status = {3'($urandom_range(0, 7)), z};
                @(negedge clock);
                exp = ref_out(ins, p, status);
                act = sample();
                checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL cbz[z=%b] phase %0d: got %h required %h", z, p, act, exp);
                end
                if (p == 3) begin
                    checks++;
                    if (PC_FS !== (z ? 2'b10 : 2'b00) || (z && k !== 32'd3)) begin
                        fails++;
                        $display("FAIL cbz_branch[z=%b]: got PC_FS %b k %h", z, PC_FS, k);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_bcond();
        instr_t ins;
        outs_t  exp, act;
        logic [3:0] sts [2];
        ins = '{kind: K_BC, op: 0, rd: 0, rn: 0, rm: 0, imm: 0, off: 2, cond: 11};
        sts[0] = {1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
        sts[1] = {1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
        for (int i = 0; i < 2; i++) begin
            IR = 32'h5400_004B;
            status = sts[i];
            for (int p = 0; p < 3; p++) begin
                @(negedge clock);
                exp = ref_out(ins, p, status);
                act = sample();
                checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL bcond_lt[%0d] phase %0d: got %h required %h", i, p, act, exp);
                end
                if (p == 2) begin
                    checks++;
                    if (PC_FS !== ((i == 0) ? 2'b10 : 2'b00)) begin
                        fails++;
                        $display("FAIL bcond_lt_pcfs[%0d]: got %b", i, PC_FS);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_random();
        instr_t ins;
        outs_t  exp, act;
        logic [31:0] ir_v;
        for (int i = 0; i < 300; i++) begin
            ins = rand_instr();
            ir_v = encode(ins);
            IR = ir_v;
            status = 4'($urandom_range(0, 15));
            for (int p = 0; p < n_phases(ins.kind); p++) begin
                if (p == 3) status = 4'($urandom_range(0, 15));
                @(negedge clock);
                exp = ref_out(ins, p, status);
                act = sample();
                checks++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL random[%0d] phase %0d ir=%h: got %h required %h",
                             i, p, ir_v, act, exp);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_halt();
        instr_t d;
        outs_t  exp, act;
        d = '{kind: K_R, op: 0, rd: 0, rn: 0, rm: 0, imm: 0, off: 0, cond: 0};
        IR = 32'h0000_0000;
        status = 4'($urandom_range(0, 15));
        for (int p = 0; p < 2; p++) begin
            @(negedge clock);
            exp = ref_out(d, p, status);
            act = sample();
            checks++;
            if (act !== exp) begin
                fails++;
                $display("FAIL halt_entry phase %0d: got %h required %h", p, act, exp);
            end
            next_cycle();
        end
        for (int c = 0; c < 20; c++) begin
            status = 4'($urandom_range(0, 15));
            @(negedge clock);
            checks++;
            if (state !== 3'd5 || halted !== 1'b1 ||
                {w_reg, mem_write_en, IR_load, status_load, mem_cs} !== 5'b00000 ||
                PC_FS !== 2'b00) begin
                fails++;
                $display("FAIL halt_hold[%0d]: got state %0d halted %b strobes %b PC_FS %b",
                         c, state, halted, {w_reg, mem_write_en, IR_load, status_load, mem_cs}, PC_FS);
            end
            next_cycle();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: got state %0d halted %b required 0/0", state, halted);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        IR = 32'h0;
        status = 4'h0;
        test_reset();
        test_alu();
        test_stur_reset();
        test_cbz();
        test_bcond();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle instruction sequencer that sits directly upstream of dataPath_core.
- Consumes the datapath's IR_out and status outputs.
- Produces every control input of the datapath each cycle: register selects, ALU function, bus/address tri-state selects, memory strobes, IR/status loads, PC function and the k constant.
- Implements a LEGv8 subset with FETCH/DECODE/EXEC/MEM/BRANCH/HALT states.

Parameters:
- DATA_SIZE, 2'b11: value driven on size (64-bit access).
- ZERO_REG, 5'd31: register index that reads zero (XZR).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other reset
- IR  in  32  instruction register contents (datapath IR_out)
- status  in  4  {V,C,N,Z}; status[0]=Z
- add_tri_sel  out  1  address source: 1=PC, 0=ALU
- data_tri_sel  out  2  data bus source: 00 ALU, 01 regB, 10 PC, 11 memory
- w_reg  out  1  register file write enable
- C0  out  1  ALU carry-in
- mem_cs  out  1  RAM chip select
- mem_write_en  out  1  RAM write strobe
- IR_load  out  1  IR capture enable
- status_load  out  1  status capture enable
- k  out  32  constant to datapath
- FS  out  5  ALU function: AND 00000, ADD 01000, SUB 01001, ORR 01100
- PC_FS  out  2  00 hold, 01 PC+4, 10 PC+4*k, 11 PC<=PC_in
- size  out  2  access size (=DATA_SIZE)
- SA, SB, DA  out  5 each  register selects
- PC_sel  out  1  PC_in source: 0=k, 1=data bus
- B_Sel  out  1  ALU B operand: 0=regB, 1=k
- halted  out  1  sticky high in HALT
- state  out  3  debug state code: FETCH 0, DECODE 1, EXEC 2, MEM 3, BRANCH 4, HALT 5

Behaviour:
- State register: asynchronously reset to FETCH. Outputs are combinational from state and IR.
- Default each cycle: all enables (w_reg, mem_write_en, IR_load, status_load, mem_cs) 0; PC_FS=00; k=0; FS=AND; C0=0; selects 0; size=DATA_SIZE.
- During reset and in the first cycle after reset, nothing writes except the FETCH strobes.
- FETCH: add_tri_sel=1, mem_cs=1, data_tri_sel=11, IR_load=1, PC_FS=01. At the edge, IR captures the instruction and PC advances by 4. Next state DECODE.
- DECODE: no strobes; classify IR. Unrecognised opcode -> HALT, otherwise -> EXEC.
- R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
  - Selects: SA=IR[9:5], SB=IR[20:16], DA=IR[4:0]; B_Sel=0, data_tri_sel=00, w_reg=1.
  - SUB: C0=1.
  - Next state FETCH.
- I-type ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000:
  - As R-type, but B_Sel=1 and k=zero-extended IR[21:10].
- LDUR 11111000010 / STUR 11111000000:
  - Address: SA=IR[9:5], k=sign-extended IR[20:12], B_Sel=1, FS=ADD, add_tri_sel=0, mem_cs=1, held through EXEC and MEM.
  - LDUR in MEM: data_tri_sel=11, DA=IR[4:0], w_reg=1.
  - STUR in EXEC and MEM: SB=IR[4:0], data_tri_sel=01. mem_write_en=1 in MEM only.
  - EXEC -> MEM -> FETCH.
- Branch offsets: PC already holds instruction address+4, so k = sign-extended offset minus 1 (32-bit two's complement). Target = instruction address + 4*offset.
- B 000101: EXEC drives PC_FS=10, k from IR[25:0]. Next FETCH.
- B.cond 01010100: cond = IR[3:0].
  - Codes: EQ 0, NE 1, HS 2, LO 3, MI 4, PL 5, VS 6, VC 7, HI 8, LS 9, GE A, LT B, GT C, LE D, AL E/F.
  - Taken -> PC_FS=10 with k from IR[23:5]; not taken -> PC_FS=00.
  - Uses status as captured before this instruction.
- CBZ 10110100 / CBNZ 10110101:
  - EXEC: SA=ZERO_REG, SB=IR[4:0], B_Sel=0, FS=ADD, status_load=1 -> BRANCH.
  - BRANCH: taken if Z=1 (CBZ) or Z=0 (CBNZ); PC_FS=10 with k from IR[23:5]. Next FETCH.
- BR 11010110000: EXEC drives SB=IR[9:5], data_tri_sel=01, PC_sel=1, PC_FS=11. Next FETCH.
- Offset edge case: offset 0 gives k=0xFFFFFFFF, so the branch re-executes itself (self-loop).
- HALT:
  - All strobes 0, halted=1, stays until reset.
  - IR=0x00000000 is illegal and halts.
- Reset asserted mid-instruction: state forced to FETCH immediately and all strobes drop in the same cycle (combinational from the reset state). A STUR interrupted in MEM must not complete its write.
- Never asserted together: IR_load with w_reg; mem_write_en with data_tri_sel=11.

Test Plan:
- Reset, then IR=ADDI X1,X0,#5 (0x91001401) -> FETCH/DECODE/EXEC; in EXEC: w_reg=1, DA=1, SA=0, B_Sel=1, k=5, FS=01000; back to FETCH in cycle 4.
- IR=SUB X5,X0,X2 (0xCB020005) -> EXEC: FS=01001, C0=1, SB=2, DA=5, B_Sel=0.
- IR=STUR X1,[X0,#-8] (0xF81F8001) -> EXEC/MEM: k=0xFFFFFFF8, add_tri_sel=0, SB=1, data_tri_sel=01; mem_write_en=1 only in MEM. Reset asserted in MEM -> mem_write_en=0 immediately, state=0.
- IR=CBZ X3,#+4 (0xB4000083):
  - status[0]=1 in BRANCH -> PC_FS=10, k=3.
  - status[0]=0 -> PC_FS=00.
- IR=B.cond with cond=LT, status={V=1,N=0} -> taken (PC_FS=10). With V=N -> PC_FS=00.
- IR=0x00000000 -> HALT after DECODE, halted=1 held for 20 cycles, all strobes 0; reset -> state=0, halted=0.
